// File: rtl/iic_target_pkg.sv
// Shared types and constants for the I2C register-file responder.
package iic_target_pkg;

  localparam int unsigned SyncStages = 2;

  localparam logic AckBit  = 1'b0;
  localparam logic NackBit = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataMack,
    StWaitStop
  } iic_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/iic_bus_sync.sv
// Synchronises raw SCL/SDA into sys_clk and derives edge and START/STOP events.
module iic_bus_sync
  import iic_target_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SyncStages-1:0] scl_sync_q, sda_sync_q;
  logic                  scl_hist_q, sda_hist_q;
  logic                  scl_s;

  // Reset to the idle (released) bus level so no spurious events follow reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SyncStages-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SyncStages-2:0], sda_in};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SyncStages-1];
  assign sda_s = sda_sync_q[SyncStages-1];

  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/iic_target_regs.sv
// I2C responder with a byte-wide register file, auto-incrementing pointer,
// write strobe output and a local read port.
module iic_target_regs
  import iic_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h3B,
  parameter int unsigned REG_AW   = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              iic_scl_in,
  input  logic              iic_sda_in,
  output logic              iic_sda_oe,
  output logic              reg_wr_pulse,
  output logic [7:0]        reg_wr_addr,
  output logic [7:0]        reg_wr_data,
  input  logic [REG_AW-1:0] loc_rd_addr,
  output logic [7:0]        loc_rd_data,
  output logic              busy,
  output logic [7:0]        nack_cnt
);

  localparam int unsigned NumRegs = 1 << REG_AW;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  iic_bus_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .scl_in    (iic_scl_in),
    .sda_in    (iic_sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  iic_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic [7:0] nack_q, nack_d;
  logic       mack_q, mack_d;
  logic       wr_pulse_q, wr_pulse_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       reg_we;
  logic [7:0] regs_q [NumRegs];
  logic [7:0] loc_rd_data_q;
  logic [7:0] ptr_inc, rd_byte, nxt_byte;

  assign ptr_inc  = ptr_q + 8'd1;
  assign rd_byte  = regs_q[ptr_q[REG_AW-1:0]];
  assign nxt_byte = regs_q[ptr_inc[REG_AW-1:0]];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    nack_d     = nack_q;
    mack_d     = mack_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    reg_we     = 1'b0;

    if (stop_det) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      if (scl_rise) begin
        case (state_q)
          StAddr, StPtr, StWdata: begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end
          StRdata:     cnt_d  = cnt_q + 4'd1;
          StRdataMack: mack_d = sda_s;
          default: ;
        endcase
      end

      if (scl_fall) begin
        case (state_q)
          StAddr: begin
            if (cnt_q == 4'd8) begin
              cnt_d = 4'd0;
              if (shift_q[7:1] == DEV_ADDR) begin
                busy_d  = 1'b1;
                oe_d    = 1'b1;
                state_d = StAddrAck;
              end else begin
                nack_d  = sat_inc8(nack_q);
                state_d = StWaitStop;
              end
            end
          end
          StAddrAck: begin
            if (shift_q[0]) begin
              shift_d = rd_byte;
              oe_d    = ~rd_byte[7];
              state_d = StRdata;
            end else begin
              oe_d    = 1'b0;
              state_d = StPtr;
            end
          end
          StPtr: begin
            if (cnt_q == 4'd8) begin
              cnt_d   = 4'd0;
              ptr_d   = shift_q;
              oe_d    = 1'b1;
              state_d = StPtrAck;
            end
          end
          StWdata: begin
            if (cnt_q == 4'd8) begin
              cnt_d      = 4'd0;
              reg_we     = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = shift_q;
              ptr_d      = ptr_inc;
              oe_d       = 1'b1;
              state_d    = StWdataAck;
            end
          end
          StPtrAck, StWdataAck: begin
            oe_d    = 1'b0;
            state_d = StWdata;
          end
          StRdata: begin
            // Bit 7 went out on entry; falls 1..7 present bits 6..0.
            if (cnt_q == 4'd8) begin
              cnt_d   = 4'd0;
              oe_d    = 1'b0;
              state_d = StRdataMack;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
          StRdataMack: begin
            if (mack_q == NackBit) begin
              oe_d    = 1'b0;
              state_d = StWaitStop;
            end else begin
              ptr_d   = ptr_inc;
              shift_d = nxt_byte;
              oe_d    = ~nxt_byte[7];
              state_d = StRdata;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= 8'd0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 8'd0;
      mack_q     <= NackBit;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
      mack_q     <= mack_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      regs_q        <= '{default: '0};
      loc_rd_data_q <= 8'd0;
    end else begin
      if (reg_we) regs_q[ptr_q[REG_AW-1:0]] <= shift_q;
      loc_rd_data_q <= regs_q[loc_rd_addr];
    end
  end

  assign iic_sda_oe   = oe_q;
  assign reg_wr_pulse = wr_pulse_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign loc_rd_data  = loc_rd_data_q;
  assign busy         = busy_q;
  assign nack_cnt     = nack_q;

endmodule

// File: tb/tb_iic_target_regs.sv
// Bench for iic_target_regs: bit-banged I2C initiator, transaction-level register model,
// and a write-strobe scoreboard drained by an independent monitor.
module tb_iic_target_regs;

  localparam logic [6:0]  Dev = 7'h3B;
  localparam int unsigned Aw  = 4;
  localparam int unsigned Nr  = 1 << Aw;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          bus_sda;
  logic          iic_sda_oe, reg_wr_pulse, busy;
  logic [7:0]    reg_wr_addr, reg_wr_data, loc_rd_data, nack_cnt;
  logic [Aw-1:0] loc_rd_addr = '0;

  assign bus_sda = sda_m & ~iic_sda_oe;

  iic_target_regs #(
    .DEV_ADDR (Dev),
    .REG_AW   (Aw)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .iic_scl_in   (scl_m),
    .iic_sda_in   (bus_sda),
    .iic_sda_oe   (iic_sda_oe),
    .reg_wr_pulse (reg_wr_pulse),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .loc_rd_addr  (loc_rd_addr),
    .loc_rd_data  (loc_rd_data),
    .busy         (busy),
    .nack_cnt     (nack_cnt)
  );

  always #10 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents, pointer and mismatch counter.
  logic [7:0]  m_regs [Nr];
  logic [7:0]  m_ptr;
  int          m_nack;
  logic [15:0] exp_wr_q [$];
  logic [7:0]  wbuf [$];
  logic [15:0] mon_e;
  logic        oe_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n && reg_wr_pulse) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected actual=%0h/%0h required=none", reg_wr_addr, reg_wr_data);
      end else begin
        mon_e = exp_wr_q.pop_front();
        chk("wr_addr", reg_wr_addr, mon_e[15:8]);
        chk("wr_data", reg_wr_data, mon_e[7:0]);
      end
    end
  end

  always @(posedge sys_clk) if (iic_sda_oe) oe_seen = 1'b1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic bit_io(input logic b, output logic r);
    wait_n(3); sda_m = b;
    wait_n(7); scl_m = 1'b1;
    wait_n(6); r = bus_sda;
    wait_n(4); scl_m = 1'b0;
  endtask

  task automatic bus_start;
    wait_n(3); sda_m = 1'b1;
    wait_n(7); scl_m = 1'b1;
    wait_n(5); sda_m = 1'b0;
    wait_n(5); scl_m = 1'b0;
  endtask

  task automatic bus_stop;
    wait_n(3); sda_m = 1'b0;
    wait_n(7); scl_m = 1'b1;
    wait_n(5); sda_m = 1'b1;
    wait_n(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    bit_io(mack, r);
  endtask

  task automatic model_reset;
    for (int i = 0; i < Nr; i++) m_regs[i] = 8'h00;
    m_ptr  = 8'h00;
    m_nack = 0;
  endtask

  // Address + pointer + bytes from wbuf; a foreign address gets no ACK anywhere.
  task automatic txn_write(input logic [6:0] a, input logic [7:0] p, input bit do_stop);
    logic ack;
    bit   hit;
    hit = (a == Dev);
    bus_start;
    send_byte({a, 1'b0}, ack);
    chk("addr_ack", ack, hit ? 0 : 1);
    if (!hit && m_nack < 255) m_nack++;
    send_byte(p, ack);
    chk("ptr_ack", ack, hit ? 0 : 1);
    if (hit) m_ptr = p;
    foreach (wbuf[i]) begin
      if (hit) begin
        exp_wr_q.push_back({m_ptr, wbuf[i]});
        m_regs[int'(m_ptr) % Nr] = wbuf[i];
        m_ptr = m_ptr + 8'd1;
      end
      send_byte(wbuf[i], ack);
      chk("data_ack", ack, hit ? 0 : 1);
    end
    if (hit) chk("busy_on", busy, 1);
    if (do_stop) begin
      bus_stop;
      chk("busy_off", busy, 0);
    end
  endtask

  // Reads n bytes from the current pointer, ACKing all but the last.
  task automatic txn_read(input int n);
    logic       ack;
    logic [7:0] d;
    bit         last;
    bus_start;
    send_byte({Dev, 1'b1}, ack);
    chk("raddr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      recv_byte(last, d);
      chk("rd_data", d, m_regs[int'(m_ptr) % Nr]);
      if (!last) m_ptr = m_ptr + 8'd1;
    end
    wait_n(6);
    chk("rd_release", iic_sda_oe, 0);
    bus_stop;
    chk("busy_off", busy, 0);
  endtask

  task automatic chk_reg(input int idx, input logic [7:0] exp);
    loc_rd_addr = Aw'(idx);
    wait_n(2);
    chk($sformatf("reg%0d", idx), loc_rd_data, exp);
  endtask

  logic       r;
  logic [7:0] abyte;
  int         kind, n;
  logic [6:0] ra;

  initial begin
    model_reset();
    wait_n(3);
    chk("rst_oe", iic_sda_oe, 0);
    chk("rst_pulse", reg_wr_pulse, 0);
    chk("rst_waddr", reg_wr_addr, 0);
    chk("rst_wdata", reg_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nack", nack_cnt, 0);
    chk("rst_rdata", loc_rd_data, 0);
    sys_rst_n = 1'b1;
    wait_n(5);

    // Plain write then combined read
    wbuf = '{8'hA5, 8'h5A};
    txn_write(Dev, 8'h02, 1'b1);
    chk_reg(3, 8'h5A);
    chk_reg(2, 8'hA5);
    wbuf = {};
    txn_write(Dev, 8'h02, 1'b0);
    txn_read(2);

    // Foreign address
    oe_seen = 1'b0;
    wbuf = '{8'h12};
    txn_write(7'h28, 8'h34, 1'b1);
    chk("foreign_oe", oe_seen, 0);
    chk("nack_cnt", nack_cnt, 1);

    // Pointer wrap
    wbuf = '{8'h11, 8'h22};
    txn_write(Dev, 8'hFF, 1'b1);
    chk_reg(15, 8'h11);
    chk_reg(0, 8'h22);

    // Abort mid-byte leaves pointer and registers untouched
    wbuf = '{8'hC3, 8'h3C};
    txn_write(Dev, 8'h05, 1'b1);
    wbuf = {};
    txn_write(Dev, 8'h05, 1'b0);
    for (int i = 0; i < 5; i++) bit_io(i[0], r);
    bus_stop;
    chk("abort_busy", busy, 0);
    txn_read(2);

    // Reset during the address ACK
    bus_start;
    abyte = {Dev, 1'b0};
    for (int i = 7; i >= 0; i--) bit_io(abyte[i], r);
    wait_n(6);
    chk("ack_drive", iic_sda_oe, 1);
    chk("ack_busy", busy, 1);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("async_oe", iic_sda_oe, 0);
    chk("async_busy", busy, 0);
    chk("async_nack", nack_cnt, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    model_reset();
    wait_n(3);
    sys_rst_n = 1'b1;
    wait_n(3);
    for (int i = 0; i < Nr; i++) chk_reg(i, 8'h00);
    wbuf = '{8'h77};
    txn_write(Dev, 8'h09, 1'b1);
    chk_reg(9, 8'h77);

    // Randomised traffic
    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(1, 4);
      wbuf = {};
      for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
      if (kind == 0) begin
        ra = ($urandom_range(0, 4) == 0) ? (Dev ^ 7'($urandom_range(1, 127))) : Dev;
        txn_write(ra, 8'($urandom), 1'b1);
      end else if (kind == 1) begin
        txn_read(n);
      end else begin
        wbuf = {};
        txn_write(Dev, 8'($urandom), 1'b0);
        txn_read(n);
      end
    end

    wait_n(5);
    chk("sb_empty", exp_wr_q.size(), 0);
    chk("nack_final", nack_cnt, m_nack);
    for (int i = 0; i < Nr; i++) chk_reg(i, m_regs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iic_target_regs.md
Name: iic_target_regs

Overview:
I2C responder with an internal byte-wide register file. It is the receiving end of the iic_tx_scl/iic_tx_sda configuration bus driven by the design's I2C initiator, which writes the HDMI transmitter setup. It oversamples SCL/SDA on sys_clk, decodes START/STOP/address/pointer/data, ACKs its own address, and supports auto-incrementing writes and reads. It serves as a synthesizable bus monitor and as a scoreboard source for the top-level bench.

Parameters:
DEV_ADDR, 7'h3B, 7-bit target address to respond to
REG_AW, 4, register file address width (2^REG_AW registers of 8 bits)

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst_n  input  1  asynchronous active-low reset
iic_scl_in  input  1  bus SCL, asynchronous
iic_sda_in  input  1  bus SDA, asynchronous
iic_sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
reg_wr_pulse  output  1  one-cycle strobe per data byte written
reg_wr_addr  output  8  pointer value of that write
reg_wr_data  output  8  data byte of that write
loc_rd_addr  input  REG_AW  local register read address
loc_rd_data  output  8  regs[loc_rd_addr], registered, 1-cycle latency
busy  output  1  1 from an addressed START to the following STOP
nack_cnt  output  8  saturating count of address-mismatch transactions

Behaviour:
- Reset is sys_rst_n, asynchronous, active-low; clock is sys_clk.
- On reset: all outputs 0, regs 0, pointer 0, state IDLE.
- Input path: 2-FF synchronizer plus one history stage per line. Edges are detected on the synchronized values, so the latency from pin edge to internal event is 3 cycles.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are valid in any state.
  - START, including a repeated START, goes to ADDR and clears the bit count.
  - STOP goes to IDLE, releases SDA, and drops busy.
- Bus timing contract: SCL high and low phases each last at least 8 sys_clk cycles.
- Sampling and driving:
  - Bits are sampled on SCL rising edges, MSB first.
  - iic_sda_oe changes only on SCL falling edges, one cycle after the internal falling-edge event.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, WAIT_STOP.
- ADDR:
  - After 8 bits, compare bits [7:1] with DEV_ADDR.
  - On a match, set busy and go to ADDR_ACK; drive SDA low from the 8th falling edge to the 9th falling edge.
  - On a mismatch, increment nack_cnt (saturate at 255), keep SDA released, and go to WAIT_STOP.
- After ADDR_ACK:
  - R/W = 0: go to PTR.
  - R/W = 1: load the shift register from regs[ptr[REG_AW-1:0]] and go to RDATA. The first data bit is driven on the 9th falling edge.
- PTR: the 8 received bits load the pointer. ACK the byte, then go to WDATA.
- WDATA:
  - After 8 bits, write regs[ptr[REG_AW-1:0]].
  - Pulse reg_wr_pulse for one cycle, with reg_wr_addr = ptr and reg_wr_data = the byte.
  - ACK, then ptr = ptr+1 (8-bit, wraps 255 to 0). Repeat.
- RDATA:
  - Drive oe = ~bit for 8 bits.
  - Release SDA at the 8th falling edge and sample the initiator's ACK/NACK at the 9th rising edge.
  - ACK (0): ptr+1, reload the shift register, continue.
  - NACK (1): go to WAIT_STOP with SDA released.
- WAIT_STOP: ignore bits; only START or STOP leaves this state.
- Register index uses only the low REG_AW pointer bits; upper pointer bits wrap the index modulo 2^REG_AW.
- STOP or START arriving mid-byte abandons the partial byte. No write occurs and the pointer is unchanged.
- Reset asserted mid-transfer releases SDA immediately (asynchronous) and clears regs.

Decomposition:
- Package iic_target_pkg holds the state enum, ACK/NACK constants, and the synchronizer depth (2).
- One sub-module is natural: iic_bus_sync. It holds the 2-FF synchronizers plus history stage and outputs scl_rise, scl_fall, start_det, stop_det, and sda_s.

Test Plan:
- Write: START, 0x76, ptr 0x02, data 0xA5 0x5A, STOP.
  - Required: ACK on all 4 bytes.
  - Required: reg_wr_pulse twice with (0x02, 0xA5) then (0x03, 0x5A).
  - Required: loc_rd_addr=3 gives 0x5A.
- Combined read: START, 0x76, ptr 0x02, repeated START, 0x77.
  - Required: read bytes 0xA5 (initiator ACK), then 0x5A (initiator NACK).
  - Required: SDA released after the NACK; busy=0 after STOP.
- Wrong address: START, 0x50, then data.
  - Required: no ACK, SDA never driven, no writes, nack_cnt=1.
- Pointer wrap: write ptr 0xFF, data 0x11 0x22.
  - Required: reg_wr_addr 0xFF then 0x00; with REG_AW=4, regs[15]=0x11 and regs[0]=0x22.
- Abort: STOP after 5 data bits.
  - Required: no reg_wr_pulse; next write transaction uses the unchanged pointer.
- Reset during an ACK phase.
  - Required: iic_sda_oe=0 asynchronously; all regs read 0; busy=0; a subsequent write succeeds.
